// File: rtl/dti_mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps

`ifndef CFG_INST_ADDR_WIDTH
`define CFG_INST_ADDR_WIDTH 32
`endif
`ifndef CFG_INST_DATA_WIDTH
`define CFG_INST_DATA_WIDTH 32
`endif

package dti_mem_arb_pkg;

  // IDLE waits for a request; each busy state owns the memory port
  // until mem_ack or the wait timer expires.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_DREAD  = 2'd2,
    ST_DWRITE = 2'd3
  } arb_state_t;

  // Who got the port last; used only to break imem/dmem ties.
  typedef enum logic {
    GRANT_IMEM = 1'b0,
    GRANT_DMEM = 1'b1
  } grant_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Instruction fetches are always full words.
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/dti_mem_arbiter_if.sv
// Bundles the imem requester, dmem requester and shared memory port signals.
// Latency: n/a (wiring only).
// Backpressure: requests are level-held until the matching ack pulse.
// Modports: slave = arbiter view (takes requests, drives acks and mem_*);
//           master = environment view (CPU requesters plus memory model).
`timescale 1ns/1ps

`ifndef CFG_INST_ADDR_WIDTH
`define CFG_INST_ADDR_WIDTH 32
`endif
`ifndef CFG_INST_DATA_WIDTH
`define CFG_INST_DATA_WIDTH 32
`endif

interface dti_mem_arbiter_if #(
  parameter int ADDR_WIDTH = `CFG_INST_ADDR_WIDTH,
  parameter int DATA_WIDTH = `CFG_INST_DATA_WIDTH
);
  // Instruction fetch requester
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_address;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_data_in;

  // Data load/store requester
  logic                  dmem_read_req;
  logic                  dmem_write_req;
  logic [ADDR_WIDTH-1:0] dmem_address;
  logic [DATA_WIDTH-1:0] dmem_data_out;
  logic [1:0]            dmem_data_size;
  logic                  dmem_read_ack;
  logic                  dmem_write_ack;
  logic [31:0]           dmem_data_in;

  // Shared memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [1:0]            mem_size;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Qualifies a requester ack as a timeout rather than a real completion
  logic                  bus_err;

  modport slave (
    input  imem_req, imem_address,
    input  dmem_read_req, dmem_write_req, dmem_address, dmem_data_out, dmem_data_size,
    input  mem_ack, mem_rdata,
    output imem_ack, imem_data_in,
    output dmem_read_ack, dmem_write_ack, dmem_data_in,
    output mem_req, mem_we, mem_address, mem_wdata, mem_size,
    output bus_err
  );

  modport master (
    output imem_req, imem_address,
    output dmem_read_req, dmem_write_req, dmem_address, dmem_data_out, dmem_data_size,
    output mem_ack, mem_rdata,
    input  imem_ack, imem_data_in,
    input  dmem_read_ack, dmem_write_ack, dmem_data_in,
    input  mem_req, mem_we, mem_address, mem_wdata, mem_size,
    input  bus_err
  );

endinterface

// File: rtl/dti_arb_timer.sv
// Wait-cycle counter for one memory transaction; flags the last allowed cycle.
// Latency: tc is combinational from the count register.
// Backpressure: none; the count saturates at terminal count until cleared.
// Ports: clk, reset_n; clear (synchronous zero), enable (count this cycle),
//        tc (this is wait cycle number TIMEOUT_CYCLES).
`timescale 1ns/1ps

module dti_arb_timer
  import dti_mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  // Busy cycle k (1-based) sees count k-1, so the TIMEOUT_CYCLES-th cycle
  // without an ack is the one where count equals TIMEOUT_CYCLES-1.
  assign tc = (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !tc) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/dti_mem_arbiter.sv
// Arbitrates imem fetches and dmem loads/stores onto one memory port with timeout.
// Latency: grant one edge after a request in IDLE; requester ack is combinational on mem_ack.
// Backpressure: requests are held until acked; requests seen while busy wait for IDLE.
// Ports: clk, reset_n (async, active-low); bus (slave modport) carries imem_*, dmem_*,
//        mem_* and bus_err.
`timescale 1ns/1ps

`ifndef CFG_INST_ADDR_WIDTH
`define CFG_INST_ADDR_WIDTH 32
`endif
`ifndef CFG_INST_DATA_WIDTH
`define CFG_INST_DATA_WIDTH 32
`endif

module dti_mem_arbiter
  import dti_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = `CFG_INST_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `CFG_INST_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  dti_mem_arbiter_if.slave  bus
);

  arb_state_t state_q, state_d;
  arb_state_t pick;
  grant_t     last_grant_q, last_grant_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            size_q;
  logic                  we_q;

  logic busy;
  logic grant;
  logic tc;
  logic ack_any;
  logic dmem_any;
  logic dmem_ack;

  assign busy     = (state_q != ST_IDLE);
  assign dmem_any = bus.dmem_read_req | bus.dmem_write_req;

  // Request selection. Stores beat loads from the same requester; an
  // imem/dmem tie goes to whichever side did not win last time.
  always_comb begin
    pick = ST_IDLE;
    if (bus.imem_req && dmem_any) begin
      if (last_grant_q == GRANT_IMEM) begin
        pick = bus.dmem_write_req ? ST_DWRITE : ST_DREAD;
      end else begin
        pick = ST_IFETCH;
      end
    end else if (bus.imem_req) begin
      pick = ST_IFETCH;
    end else if (dmem_any) begin
      pick = bus.dmem_write_req ? ST_DWRITE : ST_DREAD;
    end
  end

  assign grant = (state_q == ST_IDLE) && (pick != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_IMEM;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d      = pick;
          last_grant_d = (pick == ST_IFETCH) ? GRANT_IMEM : GRANT_DMEM;
        end
      end
      default: begin
        // Either a real completion or the timer gave up; both end the burst.
        if (bus.mem_ack || tc) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Transaction attributes are captured at grant so the requester may change
  // its inputs while the memory is still working.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
    end else if (grant) begin
      we_q    <= (pick == ST_DWRITE);
      addr_q  <= (pick == ST_IFETCH) ? bus.imem_address : bus.dmem_address;
      wdata_q <= (pick == ST_DWRITE) ? bus.dmem_data_out : '0;
      size_q  <= (pick == ST_IFETCH) ? SIZE_WORD : bus.dmem_data_size;
    end
  end

  dti_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (grant),
    .enable  (busy && !bus.mem_ack),
    .tc      (tc)
  );

  // A busy cycle ends on mem_ack or terminal count; mem_ack takes priority,
  // so bus_err is only raised when the timer alone ended the transaction.
  assign ack_any  = busy && (bus.mem_ack || tc);
  assign dmem_ack = bus.dmem_read_ack | bus.dmem_write_ack;

  assign bus.imem_ack       = ack_any && (state_q == ST_IFETCH);
  assign bus.dmem_read_ack  = ack_any && (state_q == ST_DREAD);
  assign bus.dmem_write_ack = ack_any && (state_q == ST_DWRITE);
  assign bus.bus_err        = ack_any && !bus.mem_ack;

  // Read data only passes on a genuine completion; timeouts return zero.
  assign bus.imem_data_in = (bus.imem_ack && bus.mem_ack) ? bus.mem_rdata : '0;
  assign bus.dmem_data_in = (dmem_ack && bus.mem_ack) ? 32'(bus.mem_rdata) : 32'd0;

  assign bus.mem_req     = busy;
  assign bus.mem_we      = busy && we_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_size    = size_q;

endmodule

// File: tb/tb_dti_mem_arbiter.sv
// Self-checking bench for dti_mem_arbiter with a short timeout.
// Latency: n/a.
// Backpressure: the bench plays both requesters and a fixed-latency memory.
`timescale 1ns/1ps

module tb_dti_mem_arbiter;

  typedef struct packed {
    logic [2:0]  ack;    // {imem_ack, dmem_read_ack, dmem_write_ack}
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  localparam logic [2:0] A_I = 3'b100;
  localparam logic [2:0] A_R = 3'b010;
  localparam logic [2:0] A_W = 3'b001;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  txn_t sb[$];

  dti_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dti_mem_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic txn_t mk(input logic [2:0] ack, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size,
                              input logic [31:0] rdata, input logic err);
    txn_t t;
    t.ack = ack; t.we = we; t.addr = addr; t.wdata = wdata;
    t.size = size; t.rdata = rdata; t.err = err;
    return t;
  endfunction

  task automatic clear_inputs();
    bus.imem_req       = 1'b0;
    bus.imem_address   = '0;
    bus.dmem_read_req  = 1'b0;
    bus.dmem_write_req = 1'b0;
    bus.dmem_address   = '0;
    bus.dmem_data_out  = '0;
    bus.dmem_data_size = '0;
    bus.mem_ack        = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  // One idle cycle: drive just after the edge, leave the bench at edge+3.
  task automatic tick();
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Memory model: acks in busy cycle 'lat' (0 = never). Returns what the DUT
  // presented in the ack cycle, idle cycles before mem_req rose, and busy count.
  task automatic serve(input int lat, input logic [31:0] rdata, input bit drop,
                       output txn_t obs, output int lead, output int req_cycles, output bit tmo);
    bit done;
    done = 1'b0; obs = '0; lead = 0; req_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (!done) begin
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        if (bus.mem_req !== 1'b1) begin
          if (req_cycles == 0) lead++;
        end else begin
          req_cycles++;
          bus.mem_ack   = (lat > 0) && (req_cycles == lat);
          bus.mem_rdata = bus.mem_ack ? rdata : $urandom();
          #2;
          if ({bus.imem_ack, bus.dmem_read_ack, bus.dmem_write_ack} !== 3'b000) begin
            obs.ack   = {bus.imem_ack, bus.dmem_read_ack, bus.dmem_write_ack};
            obs.we    = bus.mem_we;
            obs.addr  = bus.mem_address;
            obs.wdata = bus.mem_wdata;
            obs.size  = bus.mem_size;
            obs.err   = bus.bus_err;
            obs.rdata = bus.imem_ack ? bus.imem_data_in : bus.dmem_data_in;
            if (drop) begin
              if (bus.imem_ack)       bus.imem_req       = 1'b0;
              if (bus.dmem_read_ack)  bus.dmem_read_req  = 1'b0;
              if (bus.dmem_write_ack) bus.dmem_write_req = 1'b0;
            end
            done = 1'b1;
          end
        end
      end
    end
    tmo = !done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.imem_ack, bus.dmem_read_ack, bus.dmem_write_ack, bus.bus_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {bus.mem_req, bus.mem_we, bus.imem_ack, bus.dmem_read_ack, bus.dmem_write_ack, bus.bus_err});
    end
    checks++;
    if ({bus.mem_address, bus.mem_wdata, bus.mem_size, bus.imem_data_in, bus.dmem_data_in} !== 130'b0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h want=0", bus.mem_address, bus.mem_wdata, bus.mem_size);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b want=0", bus.mem_req);
    end
  endtask

  task automatic test_ifetch();
    txn_t obs, exp; int lead, n; bit tmo;
    bus.imem_req = 1'b1; bus.imem_address = 32'h100;
    sb.push_back(mk(A_I, 1'b0, 32'h100, 32'h0, 2'b10, 32'h13, 1'b0));
    serve(3, 32'h0000_0013, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp) begin
      failures++;
      $display("FAIL ifetch_txn got=%h want=%h tmo=%0d", obs, exp, tmo);
    end
    checks++;
    if (n != 3 || lead != 0) begin
      failures++;
      $display("FAIL ifetch_timing got req_cycles=%0d lead=%0d want 3/0", n, lead);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL ifetch_idle got mem_req=%b want=0", bus.mem_req);
    end
  endtask

  task automatic test_tie();
    txn_t obs, exp; int lead, n; bit tmo;
    do_reset();
    // Fresh reset: last grant is imem, so dmem wins the first tie.
    bus.imem_req = 1'b1; bus.imem_address = 32'h200;
    bus.dmem_read_req = 1'b1; bus.dmem_address = 32'h300; bus.dmem_data_size = 2'b00;
    sb.push_back(mk(A_R, 1'b0, 32'h300, 32'h0, 2'b00, 32'h11, 1'b0));
    sb.push_back(mk(A_I, 1'b0, 32'h200, 32'h0, 2'b10, 32'h22, 1'b0));
    serve(2, 32'h11, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp || lead != 0) begin
      failures++;
      $display("FAIL tie1_first got=%h want=%h lead=%0d", obs, exp, lead);
    end
    serve(2, 32'h22, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp || lead != 1) begin
      failures++;
      $display("FAIL tie1_second got=%h want=%h lead=%0d", obs, exp, lead);
    end
    // Lone dmem access leaves last grant at dmem, so imem wins the next tie.
    bus.dmem_read_req = 1'b1; bus.dmem_address = 32'h310; bus.dmem_data_size = 2'b01;
    sb.push_back(mk(A_R, 1'b0, 32'h310, 32'h0, 2'b01, 32'h33, 1'b0));
    serve(1, 32'h33, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp) begin
      failures++;
      $display("FAIL lone_dmem got=%h want=%h", obs, exp);
    end
    tick();
    bus.imem_req = 1'b1; bus.imem_address = 32'h210;
    bus.dmem_read_req = 1'b1; bus.dmem_address = 32'h320; bus.dmem_data_size = 2'b10;
    sb.push_back(mk(A_I, 1'b0, 32'h210, 32'h0, 2'b10, 32'h44, 1'b0));
    sb.push_back(mk(A_R, 1'b0, 32'h320, 32'h0, 2'b10, 32'h55, 1'b0));
    serve(2, 32'h44, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp) begin
      failures++;
      $display("FAIL tie2_first got=%h want=%h", obs, exp);
    end
    serve(3, 32'h55, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp) begin
      failures++;
      $display("FAIL tie2_second got=%h want=%h", obs, exp);
    end
    tick();
  endtask

  task automatic test_write_read();
    txn_t obs, exp; int lead, n; bit tmo;
    bus.dmem_write_req = 1'b1; bus.dmem_read_req = 1'b1;
    bus.dmem_address = 32'h2000; bus.dmem_data_out = 32'hDEAD_BEEF; bus.dmem_data_size = 2'b10;
    sb.push_back(mk(A_W, 1'b1, 32'h2000, 32'hDEAD_BEEF, 2'b10, 32'h0, 1'b0));
    sb.push_back(mk(A_R, 1'b0, 32'h2000, 32'h0, 2'b10, 32'hCAFE_F00D, 1'b0));
    serve(1, 32'h0, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp) begin
      failures++;
      $display("FAIL write_first got=%h want=%h", obs, exp);
    end
    serve(2, 32'hCAFE_F00D, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp || lead != 1) begin
      failures++;
      $display("FAIL read_after_write got=%h want=%h lead=%0d", obs, exp, lead);
    end
    tick();
  endtask

  task automatic test_timeout();
    txn_t obs, exp; int lead, n; bit tmo;
    bus.dmem_read_req = 1'b1; bus.dmem_address = 32'h40; bus.dmem_data_size = 2'b01;
    sb.push_back(mk(A_R, 1'b0, 32'h40, 32'h0, 2'b01, 32'h0, 1'b1));
    serve(0, 32'h0, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp) begin
      failures++;
      $display("FAIL timeout_txn got=%h want=%h tmo=%0d", obs, exp, tmo);
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL timeout_cycle got=%0d want=8", n);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_drop got mem_req=%b want=0", bus.mem_req);
    end
  endtask

  task automatic test_tc_ack();
    txn_t obs, exp; int lead, n; bit tmo;
    bus.imem_req = 1'b1; bus.imem_address = 32'h500;
    sb.push_back(mk(A_I, 1'b0, 32'h500, 32'h0, 2'b10, 32'h0000_600D, 1'b0));
    serve(8, 32'h0000_600D, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp || n != 8) begin
      failures++;
      $display("FAIL tc_ack got=%h want=%h cycles=%0d", obs, exp, n);
    end
    tick();
  endtask

  task automatic test_reset_midway();
    txn_t obs, exp; int lead, n; bit tmo;
    bus.dmem_write_req = 1'b1; bus.dmem_address = 32'h80;
    bus.dmem_data_out = 32'h55; bus.dmem_data_size = 2'b01;
    tick();
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy got req=%b we=%b want 1/1", bus.mem_req, bus.mem_we);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.imem_ack, bus.dmem_read_ack, bus.dmem_write_ack, bus.bus_err} !== 6'b0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b want=000000",
               {bus.mem_req, bus.mem_we, bus.imem_ack, bus.dmem_read_ack, bus.dmem_write_ack, bus.bus_err});
    end
    bus.dmem_write_req = 1'b0; bus.mem_ack = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.imem_req = 1'b1; bus.imem_address = 32'h400;
    sb.push_back(mk(A_I, 1'b0, 32'h400, 32'h0, 2'b10, 32'h44, 1'b0));
    serve(2, 32'h44, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp || lead != 0) begin
      failures++;
      $display("FAIL midrst_recover got=%h want=%h lead=%0d", obs, exp, lead);
    end
    tick();
  endtask

  task automatic test_idle_ack();
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({bus.imem_ack, bus.dmem_read_ack, bus.dmem_write_ack, bus.bus_err,
         bus.imem_data_in, bus.dmem_data_in} !== 68'b0) begin
      failures++;
      $display("FAIL idle_ack got acks=%b err=%b want 0",
               {bus.imem_ack, bus.dmem_read_ack, bus.dmem_write_ack}, bus.bus_err);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack_state got mem_req=%b want=0", bus.mem_req);
    end
  endtask

  task automatic test_back_to_back();
    txn_t obs, exp; int lead, n; bit tmo;
    bus.imem_req = 1'b1; bus.imem_address = 32'h700;
    sb.push_back(mk(A_I, 1'b0, 32'h700, 32'h0, 2'b10, 32'h1, 1'b0));
    sb.push_back(mk(A_I, 1'b0, 32'h700, 32'h0, 2'b10, 32'h2, 1'b0));
    serve(1, 32'h1, 1'b0, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp) begin
      failures++;
      $display("FAIL b2b_first got=%h want=%h", obs, exp);
    end
    serve(1, 32'h2, 1'b1, obs, lead, n, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || obs !== exp || lead != 1) begin
      failures++;
      $display("FAIL b2b_second got=%h want=%h lead=%0d", obs, exp, lead);
    end
    tick();
    checks++;
    if (sb.size() != 0 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got pending=%0d mem_req=%b want 0/0", sb.size(), bus.mem_req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    clear_inputs();
    #2;
    test_reset();
    test_ifetch();
    test_tie();
    test_write_read();
    test_timeout();
    test_tc_ack();
    test_reset_midway();
    test_idle_ack();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
